word_checker_param: RTL and testbench

Parametrised successor to the fixed 4-letter typing checker. Accepts a target word of 1..MAX_LEN letters over a valid/ready handshake and checks keystrokes one letter per key-release event. Reports pass/fail pulses and keeps saturating pass/fail/error counts. Sits between the word-supply register bank and the score/display logic in the typing-game datapath. Adds a strict/lenient mode with an error budget and a skip input.

---
 rtl/checker_pkg.sv | 22 ++
 rtl/word_checker_param_if.sv | 14 +
 rtl/key_event_sync.sv | 17 +
 rtl/word_checker_param.sv | 104 ++++++++++
 tb/tb_word_checker_param.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state encoding, default widths and saturating increment for word_checker_param
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TYPE = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int DEF_LETTER_W = 5;
  localparam int DEF_MAX_LEN  = 8;
  localparam int DEF_CNT_W    = 6;

  // Counters of any width up to 32 bits hold at their all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] top;
    top = (32'd1 << width) - 32'd1;
    return (value >= top) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/word_checker_param_if.sv
// rtl/word_checker_param_if.sv - word supply handshake between the register bank and the checker
interface word_checker_param_if #(
  parameter int LETTER_W = 5,
  parameter int MAX_LEN  = 8,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
);
  logic [MAX_LEN*LETTER_W-1:0] cword;
  logic [LEN_W-1:0]            clen;
  logic                        word_valid;
  logic                        word_ready;

  modport master (output cword, output clen, output word_valid, input word_ready);
  modport slave  (input cword, input clen, input word_valid, output word_ready);
endinterface

// File: rtl/key_event_sync.sv
// rtl/key_event_sync.sv - two-flop synchroniser for the key-release level plus rising-edge detect
module key_event_sync (
  input  logic clk,
  input  logic reset,
  input  logic kr,
  output logic key_evt
);
  logic [2:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], kr};
  end

  // sync[2] only delays the synchronised level so a held key yields one event.
  assign key_evt = sync[1] & ~sync[2];
endmodule

// File: rtl/word_checker_param.sv
// rtl/word_checker_param.sv - checks keystrokes against a latched target word, strict or with an error budget
module word_checker_param
  import checker_pkg::*;
#(
  parameter int LETTER_W = DEF_LETTER_W,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int IDX_W    = $clog2(MAX_LEN),
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STRICT   = 1,
  parameter int MAX_ERR  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 kr,
  input  logic [LETTER_W-1:0]  kstrk,
  word_checker_param_if.slave  wif,
  input  logic                 skip,
  output logic                 pass,
  output logic                 fail,
  output logic [IDX_W-1:0]     cletter,
  output logic [3:0]           nerr,
  output logic [CNT_W-1:0]     npassed,
  output logic [CNT_W-1:0]     nfailed
);
  state_t              state, next_state;
  logic                key_evt;
  logic [LETTER_W-1:0] letters [MAX_LEN];
  logic [LEN_W-1:0]    len_q, len_in;
  logic                hit, last_letter, err_limit, load, key_in_type;

  key_event_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .kr      (kr),
    .key_evt (key_evt)
  );

  always_comb begin
    len_in      = (32'(wif.clen) > MAX_LEN) ? LEN_W'(MAX_LEN) : wif.clen;
    hit         = (kstrk == letters[cletter]);
    last_letter = (32'(cletter) + 32'd1 == 32'(len_q));
    err_limit   = (32'(nerr) + 32'd1 == MAX_ERR);
    load        = (state == IDLE) && wif.word_valid && (len_in != '0);
    key_in_type = (state == TYPE) && !skip && key_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (load) next_state = TYPE;
      TYPE: begin
        if (skip) begin
          next_state = FAIL;
        end else if (key_evt) begin
          if (hit) begin
            if (last_letter) next_state = PASS;
          end else if (STRICT != 0 || err_limit) begin
            next_state = FAIL;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wif.word_ready = (state == IDLE);
    pass           = (state == PASS);
    fail           = (state == FAIL);
  end

  // Word latch, letter cursor, error count and the saturating score counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      cletter <= '0;
      nerr    <= '0;
      npassed <= '0;
      nfailed <= '0;
      for (int i = 0; i < MAX_LEN; i++) letters[i] <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < MAX_LEN; i++) letters[i] <= wif.cword[i*LETTER_W +: LETTER_W];
        len_q   <= len_in;
        cletter <= '0;
        nerr    <= '0;
      end else if (key_in_type) begin
        if (hit) begin
          if (!last_letter) cletter <= cletter + IDX_W'(1);
        end else if (STRICT == 0) begin
          nerr <= nerr + 4'd1;
        end
      end
      if (state == PASS) npassed <= CNT_W'(sat_inc(32'(npassed), CNT_W));
      if (state == FAIL) nfailed <= CNT_W'(sat_inc(32'(nfailed), CNT_W));
    end
  end
endmodule

// File: tb/tb_word_checker_param.sv
// tb/tb_word_checker_param.sv - strict (CNT_W=2) and lenient instances driven together against a word-level model
module tb_word_checker_param;
  localparam int LW = 5;
  localparam int ML = 8;
  localparam int CW = ML * LW;

  logic          clk = 1'b0;
  logic          reset, kr, skip, word_valid;
  logic [LW-1:0] kstrk;
  logic [CW-1:0] cword;
  logic [3:0]    clen;

  always #5 clk = ~clk;

  word_checker_param_if #(.LETTER_W(LW), .MAX_LEN(ML)) if0 ();
  word_checker_param_if #(.LETTER_W(LW), .MAX_LEN(ML)) if1 ();
  assign if0.cword = cword;  assign if0.clen = clen;  assign if0.word_valid = word_valid;
  assign if1.cword = cword;  assign if1.clen = clen;  assign if1.word_valid = word_valid;

  logic       pass0, fail0, pass1, fail1;
  logic [2:0] cl0, cl1;
  logic [3:0] ne0, ne1;
  logic [1:0] np0, nf0;
  logic [5:0] np1, nf1;

  word_checker_param #(.LETTER_W(LW), .MAX_LEN(ML), .CNT_W(2), .STRICT(1), .MAX_ERR(3)) u0 (
    .clk(clk), .reset(reset), .kr(kr), .kstrk(kstrk), .wif(if0), .skip(skip),
    .pass(pass0), .fail(fail0), .cletter(cl0), .nerr(ne0), .npassed(np0), .nfailed(nf0));
  word_checker_param #(.LETTER_W(LW), .MAX_LEN(ML), .CNT_W(6), .STRICT(0), .MAX_ERR(3)) u1 (
    .clk(clk), .reset(reset), .kr(kr), .kstrk(kstrk), .wif(if1), .skip(skip),
    .pass(pass1), .fail(fail1), .cletter(cl1), .nerr(ne1), .npassed(np1), .nfailed(nf1));

  int n_tests = 0, n_fail = 0;
  bit m_act[2];
  int m_idx[2], m_err[2], m_np[2], m_nf[2];
  bit e_pass[2], e_fail[2];
  int m_len;
  int m_word[ML];
  int cmax[2] = '{3, 63};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cl0"}, 32'(cl0), m_idx[0]);
    check({tag, ".ne0"}, 32'(ne0), m_err[0]);
    check({tag, ".pass0"}, 32'(pass0), 32'(e_pass[0]));
    check({tag, ".fail0"}, 32'(fail0), 32'(e_fail[0]));
    check({tag, ".np0"}, 32'(np0), m_np[0]);
    check({tag, ".nf0"}, 32'(nf0), m_nf[0]);
    check({tag, ".rdy0"}, 32'(if0.word_ready), 32'(!m_act[0] && !e_pass[0] && !e_fail[0]));
    check({tag, ".cl1"}, 32'(cl1), m_idx[1]);
    check({tag, ".ne1"}, 32'(ne1), m_err[1]);
    check({tag, ".pass1"}, 32'(pass1), 32'(e_pass[1]));
    check({tag, ".fail1"}, 32'(fail1), 32'(e_fail[1]));
    check({tag, ".np1"}, 32'(np1), m_np[1]);
    check({tag, ".nf1"}, 32'(nf1), m_nf[1]);
    check({tag, ".rdy1"}, 32'(if1.word_ready), 32'(!m_act[1] && !e_pass[1] && !e_fail[1]));
  endtask

  function automatic void end_word(int i, bit ok);
    m_act[i] = 1'b0;
    if (ok) e_pass[i] = 1'b1;
    else    e_fail[i] = 1'b1;
  endfunction

  function automatic void model_key(int k, bit sk);
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i]) continue;
      if (sk) end_word(i, 1'b0);
      else if (k == m_word[m_idx[i]]) begin
        if (m_idx[i] == m_len - 1) end_word(i, 1'b1);
        else m_idx[i]++;
      end else if (i == 0) end_word(i, 1'b0);
      else begin
        m_err[i]++;
        if (m_err[i] == 3) end_word(i, 1'b0);
      end
    end
  endfunction

  function automatic void settle();
    for (int i = 0; i < 2; i++) begin
      if (e_pass[i] && m_np[i] < cmax[i]) m_np[i]++;
      if (e_fail[i] && m_nf[i] < cmax[i]) m_nf[i]++;
      e_pass[i] = 1'b0;
      e_fail[i] = 1'b0;
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_idx[i] = 0; m_err[i] = 0; m_np[i] = 0; m_nf[i] = 0;
      e_pass[i] = 0; e_fail[i] = 0;
    end
    check_all("rst");
  endtask

  task automatic load(input int len_raw);
    for (int i = 0; i < ML; i++) cword[i*LW +: LW] = LW'(m_word[i]);
    clen = 4'(len_raw);
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    cword = CW'({$urandom(), $urandom()});
    m_len = (len_raw > ML) ? ML : len_raw;
    if (m_len != 0)
      for (int i = 0; i < 2; i++) begin m_act[i] = 1; m_idx[i] = 0; m_err[i] = 0; end
    check_all("load");
  endtask

  // kr rises just after an edge; the event is acted on at the third edge after that.
  task automatic press(input int k, input int h, input bit sk);
    int last;
    last = ((h > 4) ? h : 4) + 3;
    kstrk = LW'(k);
    kr = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == h) kr = 1'b0;
      if (sk && c == 2) skip = 1'b1;
      if (c == 3) begin
        skip = 1'b0;
        model_key(k, sk);
        check_all("key");
      end
      if (c == 4) begin
        settle();
        check_all("post");
      end
    end
  endtask

  task automatic abandon();
    if (m_act[0] || m_act[1]) begin
      skip = 1'b1;
      @(posedge clk); #1;
      skip = 1'b0;
      model_key(0, 1'b1);
      check_all("skip");
      @(posedge clk); #1;
      settle();
      check_all("skip_post");
    end
  endtask

  always @(negedge clk) begin
    if (pass0 || fail0) check("excl0", 32'(pass0 & fail0), 32'd0);
    if (pass1 || fail1) check("excl1", 32'(pass1 & fail1), 32'd0);
  end

  initial begin
    reset = 1'b1; kr = 1'b0; skip = 1'b0; word_valid = 1'b0;
    kstrk = '0; cword = '0; clen = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    m_word = '{3, 1, 20, 8, 0, 0, 0, 0};
    load(4);
    foreach (m_word[i]) if (i < 4) press(m_word[i], 1, 1'b0);

    load(4);
    press(3, 2, 1'b0);
    press(9, 2, 1'b0);
    abandon();

    m_word = '{5, 6, 0, 0, 0, 0, 0, 0};
    load(2);
    press(7, 1, 1'b0); press(5, 1, 1'b0); press(7, 1, 1'b0); press(7, 1, 1'b0);
    abandon();

    load(0);
    m_word = '{1, 2, 3, 4, 5, 6, 7, 9};
    load(15);
    press(1, 20, 1'b0);
    press(2, 3, 1'b0);
    for (int i = 2; i < ML; i++) press(m_word[i], 1, 1'b0);

    load(4);
    press(1, 1, 1'b0); press(2, 1, 1'b0);
    press(3, 1, 1'b1);
    load(4);
    press(1, 1, 1'b0); press(2, 1, 1'b0);
    do_reset();

    for (int w = 0; w < 5; w++) begin
      m_word[0] = w % 4;
      load(1);
      press(m_word[0], 2, 1'b0);
      check("sat_np0", 32'(np0), (w + 1 > 3) ? 32'd3 : 32'(w + 1));
    end

    for (int w = 0; w < 40; w++) begin
      int presses;
      for (int i = 0; i < ML; i++) m_word[i] = $urandom_range(0, 3);
      load($urandom_range(0, 10));
      presses = 0;
      while ((m_act[0] || m_act[1]) && presses < 12) begin
        int k;
        if ($urandom_range(0, 9) < 7) k = m_act[1] ? m_word[m_idx[1]] : m_word[m_idx[0]];
        else k = $urandom_range(0, 3);
        press(k, $urandom_range(1, 5), ($urandom_range(0, 9) == 0));
        presses++;
      end
      abandon();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
